// File: rtl/l1_dm_store_buf_pkg.sv
// Shared types for the L1 data-cache store buffer: entry layout, control states
// and the byte-merge helper used when a store coalesces into the youngest entry.
package l1_dm_pkg;

    localparam int L1_WIDTH = 32;
    localparam int L1_DEPTH = 1024;
    localparam int L1_AW    = $clog2(L1_DEPTH);
    localparam int L1_BE    = L1_WIDTH / 8;

    typedef struct packed {
        logic [L1_AW-1:0]    addr;
        logic [L1_BE-1:0]    wbe;
        logic [L1_WIDTH-1:0] data;
    } sb_entry_t;

    typedef enum logic [1:0] {
        SB_IDLE,
        SB_FLUSH,
        SB_DONE
    } sb_state_e;

    // Newer bytes overwrite older ones; the enable mask accumulates.
    function automatic sb_entry_t sb_merge(input sb_entry_t old_e,
                                           input logic [L1_BE-1:0] wbe,
                                           input logic [L1_WIDTH-1:0] data);
        sb_entry_t m;
        m     = old_e;
        m.wbe = old_e.wbe | wbe;
        for (int b = 0; b < L1_BE; b++) begin
            if (wbe[b]) begin
                m.data[8*b +: 8] = data[8*b +: 8];
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/l1_dm_store_buf_if.sv
// Core-side load/store/flush handshakes plus the data-SRAM port of the store buffer.
// slave is the store buffer; master is the core and SRAM side.
interface l1_dm_store_buf_if
    import l1_dm_pkg::*;
#(
    parameter int WIDTH = L1_WIDTH,
    parameter int AW    = L1_AW
) ();

    logic               ld_req_val;
    logic [AW-1:0]      ld_req_addr;
    logic               ld_req_ack;
    logic               ld_resp_val;
    logic [WIDTH-1:0]   ld_resp_data;

    logic               st_req_val;
    logic [AW-1:0]      st_req_addr;
    logic [WIDTH/8-1:0] st_req_wbe;
    logic [WIDTH-1:0]   st_req_wdata;
    logic               st_req_ack;

    logic               flush_req;
    logic               flush_done;
    logic               sb_empty;
    logic               sb_full;

    logic               mem_en;
    logic [AW-1:0]      mem_addr;
    logic               mem_we;
    logic [WIDTH/8-1:0] mem_wbe;
    logic [WIDTH-1:0]   mem_wdata;
    logic [WIDTH-1:0]   mem_rdata;

    modport slave (
        input  ld_req_val, ld_req_addr, st_req_val, st_req_addr, st_req_wbe, st_req_wdata,
               flush_req, mem_rdata,
        output ld_req_ack, ld_resp_val, ld_resp_data, st_req_ack, flush_done, sb_empty, sb_full,
               mem_en, mem_addr, mem_we, mem_wbe, mem_wdata
    );

    modport master (
        output ld_req_val, ld_req_addr, st_req_val, st_req_addr, st_req_wbe, st_req_wdata,
               flush_req, mem_rdata,
        input  ld_req_ack, ld_resp_val, ld_resp_data, st_req_ack, flush_done, sb_empty, sb_full,
               mem_en, mem_addr, mem_we, mem_wbe, mem_wdata
    );

endinterface

// File: rtl/l1_dm_store_buf_sb_fifo.sv
// Store-buffer entry storage: circular FIFO with merge into the youngest entry
// and a parallel address compare of every valid entry against the load address.
module l1_dm_sb_fifo
    import l1_dm_pkg::*;
#(
    parameter int SB_DEPTH = 4
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        push_i,
    input  logic                        merge_i,
    input  logic                        pop_i,
    input  sb_entry_t                   wr_entry_i,
    input  logic [L1_AW-1:0]            ld_addr_i,
    output sb_entry_t                   head_o,
    output logic [$clog2(SB_DEPTH):0]   count_o,
    output logic [$clog2(SB_DEPTH):0]   count_nxt_o,
    output logic [SB_DEPTH-1:0]         hit_o,
    output logic                        tail_match_o,
    output logic                        empty_o,
    output logic                        full_o
);

    localparam int PW = $clog2(SB_DEPTH);
    localparam int CW = PW + 1;

    sb_entry_t             entry_q [SB_DEPTH];
    logic [SB_DEPTH-1:0]   valid_q;
    logic [PW-1:0]         wr_ptr_q;
    logic [PW-1:0]         rd_ptr_q;
    logic [PW-1:0]         tail_ptr;
    logic [CW-1:0]         count_q;
    logic [CW-1:0]         count_d;

    assign tail_ptr     = wr_ptr_q - PW'(1);
    assign head_o       = entry_q[rd_ptr_q];
    assign tail_match_o = valid_q[tail_ptr] & (entry_q[tail_ptr].addr == wr_entry_i.addr);
    assign count_d      = count_q + CW'(push_i) - CW'(pop_i);
    assign count_o      = count_q;
    assign count_nxt_o  = count_d;
    assign empty_o      = (count_q == '0);
    assign full_o       = (count_q == CW'(SB_DEPTH));

    always_comb begin
        hit_o = '0;
        for (int i = 0; i < SB_DEPTH; i++) begin
            hit_o[i] = valid_q[i] & (entry_q[i].addr == ld_addr_i);
        end
    end

    // Push never targets the head slot while a pop is in flight: push needs !full,
    // pop needs !empty, so the two pointers differ whenever both fire.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < SB_DEPTH; i++) begin
                entry_q[i] <= '0;
            end
        end else begin
            if (pop_i) begin
                valid_q[rd_ptr_q] <= 1'b0;
                rd_ptr_q          <= rd_ptr_q + PW'(1);
            end
            if (push_i) begin
                valid_q[wr_ptr_q] <= 1'b1;
                entry_q[wr_ptr_q] <= wr_entry_i;
                wr_ptr_q          <= wr_ptr_q + PW'(1);
            end else if (merge_i) begin
                entry_q[tail_ptr] <= sb_merge(entry_q[tail_ptr], wr_entry_i.wbe, wr_entry_i.data);
            end
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/l1_dm_store_buf.sv
// Write-back store buffer and single-port arbiter in front of the L1 data SRAM.
//   state    | meaning
//   SB_IDLE  | normal operation: stores accepted, loads and drains share the port
//   SB_FLUSH | draining every entry; loads and stores held off
//   SB_DONE  | buffer drained; flush_done pulses for this one cycle
module l1_dm_store_buf
    import l1_dm_pkg::*;
#(
    parameter int WIDTH    = L1_WIDTH,
    parameter int DEPTH    = L1_DEPTH,
    parameter int SB_DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    l1_dm_store_buf_if.slave bus_io
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(SB_DEPTH) + 1;

    sb_state_e           state_q, state_d;
    logic                ld_resp_val_q;

    sb_entry_t           head;
    sb_entry_t           wr_entry;
    logic [CW-1:0]       count;
    logic [CW-1:0]       count_nxt;
    logic [SB_DEPTH-1:0] hit;
    logic                tail_match, empty, full;

    logic                hazard, force_drain, ld_ack, drain, merge, st_ack, push;
    logic [AW-1:0]       mem_addr;
    logic [WIDTH/8-1:0]  mem_wbe;
    logic [WIDTH-1:0]    mem_wdata;

    assign wr_entry = '{addr: bus_io.st_req_addr, wbe: bus_io.st_req_wbe, data: bus_io.st_req_wdata};

    l1_dm_sb_fifo #(.SB_DEPTH(SB_DEPTH)) u_fifo (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .push_i       (push),
        .merge_i      (st_ack & merge),
        .pop_i        (drain),
        .wr_entry_i   (wr_entry),
        .ld_addr_i    (bus_io.ld_req_addr),
        .head_o       (head),
        .count_o      (count),
        .count_nxt_o  (count_nxt),
        .hit_o        (hit),
        .tail_match_o (tail_match),
        .empty_o      (empty),
        .full_o       (full)
    );

    // A draining head cannot also absorb a merge, and a same-cycle pop never
    // frees a slot for the incoming store.
    always_comb begin
        hazard      = bus_io.ld_req_val & (|hit);
        force_drain = !empty & ((state_q == SB_FLUSH) | full | hazard);
        ld_ack      = bus_io.ld_req_val & !force_drain & (state_q != SB_FLUSH);
        drain       = force_drain | (!empty & !ld_ack);
        merge       = tail_match & !(drain & (count == CW'(1)));
        st_ack      = bus_io.st_req_val & (state_q == SB_IDLE) & (!full | merge);
        push        = st_ack & !merge;
    end

    always_comb begin
        mem_addr  = '0;
        mem_wbe   = '0;
        mem_wdata = '0;
        if (drain) begin
            mem_addr  = head.addr;
            mem_wbe   = head.wbe;
            mem_wdata = head.data;
        end else if (ld_ack) begin
            mem_addr  = bus_io.ld_req_addr;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            SB_IDLE:  if (bus_io.flush_req) state_d = SB_FLUSH;
            SB_FLUSH: if (count_nxt == '0) state_d = SB_DONE;
            SB_DONE:  state_d = SB_IDLE;
            default:  state_d = SB_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= SB_IDLE;
            ld_resp_val_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            ld_resp_val_q <= ld_ack;
        end
    end

    assign bus_io.ld_req_ack   = ld_ack;
    assign bus_io.ld_resp_val  = ld_resp_val_q;
    assign bus_io.ld_resp_data = bus_io.mem_rdata;
    assign bus_io.st_req_ack   = st_ack;
    assign bus_io.flush_done   = (state_q == SB_DONE);
    assign bus_io.sb_empty     = empty;
    assign bus_io.sb_full      = full;
    assign bus_io.mem_en       = drain | ld_ack;
    assign bus_io.mem_we       = drain;
    assign bus_io.mem_addr     = mem_addr;
    assign bus_io.mem_wbe      = mem_wbe;
    assign bus_io.mem_wdata    = mem_wdata;

endmodule

// File: tb/tb_l1_dm_store_buf.sv
// Bench for l1_dm_store_buf: SRAM model, golden memory and write/load scoreboards,
// with one task per scenario.
module tb_l1_dm_store_buf;
    import l1_dm_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int n_tests  = 0;
    int n_fail   = 0;
    int n_writes = 0;

    sb_entry_t   wr_q[$];
    logic [31:0] ld_q[$];
    bit   [31:0] sram_raw [1024];
    bit   [31:0] gold_raw [1024];
    logic [31:0] sram_m;
    logic [31:0] mon_m;
    logic [31:0] mon_v;
    sb_entry_t   mon_e;

    l1_dm_store_buf_if bus ();

    l1_dm_store_buf dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus_io (bus)
    );

    always #5 clk = ~clk;

    // Memories hold value ^ pat(addr) so zero-initialised storage reads as a known pattern.
    function automatic logic [31:0] pat(input logic [L1_AW-1:0] a);
        return 32'hA55A0000 | {22'd0, a};
    endfunction

    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) begin
                for (int b = 0; b < 4; b++) sram_m[8*b +: 8] = {8{bus.mem_wbe[b]}};
                sram_raw[bus.mem_addr] <= (sram_raw[bus.mem_addr] & ~sram_m) |
                                          ((bus.mem_wdata ^ pat(bus.mem_addr)) & sram_m);
            end else begin
                bus.mem_rdata <= sram_raw[bus.mem_addr] ^ pat(bus.mem_addr);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.ld_resp_val) begin
                n_tests++;
                if (ld_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL ld_resp_extra: got data %h, expected no response", bus.ld_resp_data);
                end else begin
                    mon_v = ld_q.pop_front();
                    if (bus.ld_resp_data !== mon_v) begin
                        n_fail++;
                        $display("FAIL ld_resp_data: got %h expected %h", bus.ld_resp_data, mon_v);
                    end
                end
            end
            if (bus.mem_en && bus.mem_we) begin
                n_writes++;
                n_tests++;
                if (wr_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_write: got addr %h wbe %h data %h, expected none",
                             bus.mem_addr, bus.mem_wbe, bus.mem_wdata);
                end else begin
                    mon_e = wr_q.pop_front();
                    if (bus.mem_addr !== mon_e.addr || bus.mem_wbe !== mon_e.wbe || bus.mem_wdata !== mon_e.data) begin
                        n_fail++;
                        $display("FAIL sram_write: got addr %h wbe %h data %h expected addr %h wbe %h data %h",
                                 bus.mem_addr, bus.mem_wbe, bus.mem_wdata, mon_e.addr, mon_e.wbe, mon_e.data);
                    end
                end
            end
            // Load is older than a same-cycle store, so sample gold before applying the store.
            if (bus.ld_req_ack) ld_q.push_back(gold_raw[bus.ld_req_addr] ^ pat(bus.ld_req_addr));
            if (bus.st_req_ack) begin
                for (int b = 0; b < 4; b++) mon_m[8*b +: 8] = {8{bus.st_req_wbe[b]}};
                gold_raw[bus.st_req_addr] = (gold_raw[bus.st_req_addr] & ~mon_m) |
                                            ((bus.st_req_wdata ^ pat(bus.st_req_addr)) & mon_m);
            end
        end
    end

    task automatic drive_idle();
        bus.ld_req_val   = 1'b0;
        bus.ld_req_addr  = '0;
        bus.st_req_val   = 1'b0;
        bus.st_req_addr  = '0;
        bus.st_req_wbe   = '0;
        bus.st_req_wdata = '0;
        bus.flush_req    = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_store(input logic [9:0] a, input logic [3:0] be, input logic [31:0] d);
        bus.st_req_val   = 1'b1;
        bus.st_req_addr  = a;
        bus.st_req_wbe   = be;
        bus.st_req_wdata = d;
    endtask

    task automatic test_reset();
        drive_idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if (bus.sb_empty !== 1'b1) begin
            n_fail++; $display("FAIL reset_empty: got %b expected 1", bus.sb_empty);
        end
        n_tests++;
        if ({bus.mem_en, bus.mem_we, bus.ld_resp_val, bus.flush_done, bus.sb_full, bus.st_req_ack, bus.ld_req_ack} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got en%b we%b rv%b fd%b full%b sa%b la%b expected all 0",
                     bus.mem_en, bus.mem_we, bus.ld_resp_val, bus.flush_done, bus.sb_full, bus.st_req_ack, bus.ld_req_ack);
        end
        n_tests++;
        if (bus.mem_addr !== '0 || bus.mem_wbe !== '0 || bus.mem_wdata !== '0) begin
            n_fail++; $display("FAIL reset_bus: got addr %h wbe %h data %h expected 0", bus.mem_addr, bus.mem_wbe, bus.mem_wdata);
        end
        step();
        rst_n = 1'b1;
        @(negedge clk);
        n_tests++;
        if (bus.sb_empty !== 1'b1 || bus.mem_en !== 1'b0) begin
            n_fail++; $display("FAIL post_reset: got empty %b en %b expected 1 0", bus.sb_empty, bus.mem_en);
        end
    endtask

    task automatic test_single_store();
        step();
        set_store(10'h10, 4'hF, 32'h11223344);
        wr_q.push_back('{addr: 10'h10, wbe: 4'hF, data: 32'h11223344});
        @(negedge clk);
        n_tests++;
        if (bus.st_req_ack !== 1'b1 || bus.mem_en !== 1'b0) begin
            n_fail++; $display("FAIL single_accept: got ack %b en %b expected 1 0", bus.st_req_ack, bus.mem_en);
        end
        step();
        drive_idle();
        @(negedge clk);
        n_tests++;
        if (bus.mem_we !== 1'b1 || bus.mem_addr !== 10'h10 || bus.mem_wdata !== 32'h11223344) begin
            n_fail++;
            $display("FAIL single_drain: got we %b addr %h data %h expected 1 010 11223344", bus.mem_we, bus.mem_addr, bus.mem_wdata);
        end
        step();
        @(negedge clk);
        n_tests++;
        if (bus.sb_empty !== 1'b1 || bus.mem_en !== 1'b0) begin
            n_fail++; $display("FAIL single_empty: got empty %b en %b expected 1 0", bus.sb_empty, bus.mem_en);
        end
    endtask

    task automatic test_merge();
        int cyc;
        step();
        bus.ld_req_val  = 1'b1;
        bus.ld_req_addr = 10'h30;
        set_store(10'h20, 4'h3, 32'h0000AAAA);
        wr_q.push_back('{addr: 10'h20, wbe: 4'hF, data: 32'hBBBBAAAA});
        @(negedge clk);
        step();
        set_store(10'h20, 4'hC, 32'hBBBB0000);
        @(negedge clk);
        n_tests++;
        if (bus.st_req_ack !== 1'b1 || bus.ld_req_ack !== 1'b1 || bus.mem_we !== 1'b0) begin
            n_fail++;
            $display("FAIL merge_accept: got st_ack %b ld_ack %b we %b expected 1 1 0", bus.st_req_ack, bus.ld_req_ack, bus.mem_we);
        end
        step();
        bus.st_req_val = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_tests++;
            if (bus.ld_req_ack !== 1'b1 || bus.sb_empty !== 1'b0) begin
                n_fail++; $display("FAIL merge_load_grant: got ack %b empty %b expected 1 0", bus.ld_req_ack, bus.sb_empty);
            end
            step();
        end
        drive_idle();
        cyc = 0;
        while (bus.sb_empty !== 1'b1 && cyc < 10) begin
            step();
            cyc++;
        end
        step();
        n_tests++;
        if (cyc >= 10 || wr_q.size() != 0) begin
            n_fail++; $display("FAIL merge_drain: got pending %0d after %0d cycles expected 0", wr_q.size(), cyc);
        end
    endtask

    task automatic test_hazard();
        step();
        bus.ld_req_val  = 1'b1;
        bus.ld_req_addr = 10'h31;
        set_store(10'h40, 4'hF, 32'hCAFEF00D);
        wr_q.push_back('{addr: 10'h40, wbe: 4'hF, data: 32'hCAFEF00D});
        @(negedge clk);
        step();
        bus.st_req_val  = 1'b0;
        bus.ld_req_addr = 10'h40;
        @(negedge clk);
        n_tests++;
        if (bus.ld_req_ack !== 1'b0 || bus.mem_we !== 1'b1 || bus.mem_addr !== 10'h40) begin
            n_fail++;
            $display("FAIL hazard_stall: got ack %b we %b addr %h expected 0 1 040", bus.ld_req_ack, bus.mem_we, bus.mem_addr);
        end
        step();
        @(negedge clk);
        n_tests++;
        if (bus.ld_req_ack !== 1'b1) begin
            n_fail++; $display("FAIL hazard_grant: got ack %b expected 1", bus.ld_req_ack);
        end
        step();
        drive_idle();
        @(negedge clk);
        n_tests++;
        if (bus.ld_resp_val !== 1'b1 || bus.ld_resp_data !== 32'hCAFEF00D) begin
            n_fail++; $display("FAIL hazard_data: got val %b data %h expected 1 cafef00d", bus.ld_resp_val, bus.ld_resp_data);
        end
    endtask

    task automatic test_full();
        int cyc;
        step();
        bus.ld_req_val  = 1'b1;
        bus.ld_req_addr = 10'h32;
        for (int i = 0; i < 5; i++) begin
            set_store(10'h50 + 10'(i), 4'hF, 32'h5000_0000 + 32'(i));
            wr_q.push_back('{addr: 10'h50 + 10'(i), wbe: 4'hF, data: 32'h5000_0000 + 32'(i)});
            @(negedge clk);
            n_tests++;
            if (i < 4 && bus.st_req_ack !== 1'b1) begin
                n_fail++; $display("FAIL full_fill: store %0d got ack %b expected 1", i, bus.st_req_ack);
            end else if (i == 4 && (bus.st_req_ack !== 1'b0 || bus.sb_full !== 1'b1 ||
                                    bus.mem_we !== 1'b1 || bus.ld_req_ack !== 1'b0)) begin
                n_fail++;
                $display("FAIL full_stall: got ack %b full %b we %b ld_ack %b expected 0 1 1 0",
                         bus.st_req_ack, bus.sb_full, bus.mem_we, bus.ld_req_ack);
            end
            step();
        end
        @(negedge clk);
        n_tests++;
        if (bus.st_req_ack !== 1'b1 || bus.sb_full !== 1'b0) begin
            n_fail++; $display("FAIL full_retry: got ack %b full %b expected 1 0", bus.st_req_ack, bus.sb_full);
        end
        step();
        drive_idle();
        cyc = 0;
        while (bus.sb_empty !== 1'b1 && cyc < 12) begin
            step();
            cyc++;
        end
        step();
        n_tests++;
        if (cyc >= 12 || wr_q.size() != 0) begin
            n_fail++; $display("FAIL full_drain: got pending %0d after %0d cycles expected 0", wr_q.size(), cyc);
        end
    endtask

    task automatic test_flush();
        int wr_cnt;
        int cyc;
        step();
        bus.ld_req_val  = 1'b1;
        bus.ld_req_addr = 10'h33;
        for (int i = 0; i < 3; i++) begin
            set_store(10'h70 + 10'(i), 4'hF, 32'h7000_0000 + 32'(i));
            wr_q.push_back('{addr: 10'h70 + 10'(i), wbe: 4'hF, data: 32'h7000_0000 + 32'(i)});
            step();
        end
        bus.st_req_val = 1'b0;
        bus.flush_req  = 1'b1;
        step();
        bus.flush_req = 1'b0;
        set_store(10'h7F, 4'hF, 32'hDEADBEEF);
        wr_cnt = 0;
        cyc    = 0;
        @(negedge clk);
        while (bus.flush_done !== 1'b1 && cyc < 10) begin
            n_tests++;
            if (bus.st_req_ack !== 1'b0 || bus.ld_req_ack !== 1'b0) begin
                n_fail++; $display("FAIL flush_block: got st_ack %b ld_ack %b expected 0 0", bus.st_req_ack, bus.ld_req_ack);
            end
            if (bus.mem_we === 1'b1) wr_cnt++;
            cyc++;
            @(negedge clk);
        end
        n_tests++;
        if (bus.st_req_ack !== 1'b0) begin
            n_fail++; $display("FAIL flush_done_block: got st_ack %b expected 0", bus.st_req_ack);
        end
        step();
        drive_idle();
        n_tests++;
        if (wr_cnt != 3 || cyc != 3) begin
            n_fail++; $display("FAIL flush_writes: got %0d writes in %0d cycles expected 3 in 3", wr_cnt, cyc);
        end
        @(negedge clk);
        n_tests++;
        if (bus.flush_done !== 1'b0 || bus.sb_empty !== 1'b1) begin
            n_fail++; $display("FAIL flush_pulse: got done %b empty %b expected 0 1", bus.flush_done, bus.sb_empty);
        end
    endtask

    task automatic test_flush_empty();
        logic [2:0] seen;
        step();
        bus.flush_req = 1'b1;
        @(negedge clk);
        seen[0] = bus.flush_done;
        step();
        bus.flush_req = 1'b0;
        @(negedge clk);
        seen[1] = bus.flush_done;
        step();
        @(negedge clk);
        seen[2] = bus.flush_done;
        n_tests++;
        if (seen !== 3'b100) begin
            n_fail++; $display("FAIL flush_empty: got done history %b expected 100", seen);
        end
        step();
        @(negedge clk);
        n_tests++;
        if (bus.flush_done !== 1'b0) begin
            n_fail++; $display("FAIL flush_empty_pulse: got %b expected 0", bus.flush_done);
        end
    endtask

    task automatic test_reset_mid();
        int w0;
        step();
        bus.ld_req_val  = 1'b1;
        bus.ld_req_addr = 10'h34;
        set_store(10'h60, 4'hF, 32'h6000_0001);
        wr_q.push_back('{addr: 10'h60, wbe: 4'hF, data: 32'h6000_0001});
        step();
        set_store(10'h61, 4'hF, 32'h6000_0002);
        wr_q.push_back('{addr: 10'h61, wbe: 4'hF, data: 32'h6000_0002});
        step();
        drive_idle();
        #2;
        n_tests++;
        if (bus.mem_we !== 1'b1 || bus.mem_addr !== 10'h60) begin
            n_fail++; $display("FAIL reset_mid_drain: got we %b addr %h expected 1 060", bus.mem_we, bus.mem_addr);
        end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (bus.mem_en !== 1'b0 || bus.sb_empty !== 1'b1) begin
            n_fail++; $display("FAIL reset_mid_async: got en %b empty %b expected 0 1", bus.mem_en, bus.sb_empty);
        end
        wr_q.delete();
        ld_q.delete();
        repeat (2) step();
        rst_n = 1'b1;
        w0 = n_writes;
        repeat (8) step();
        n_tests++;
        if (n_writes != w0 || bus.sb_empty !== 1'b1) begin
            n_fail++; $display("FAIL reset_mid_quiet: got %0d writes empty %b expected 0 1", n_writes - w0, bus.sb_empty);
        end
    endtask

    initial begin
        drive_idle();
        test_reset();
        test_single_store();
        test_merge();
        test_hazard();
        test_full();
        test_flush();
        test_flush_empty();
        test_reset_mid();
        step();
        n_tests++;
        if (ld_q.size() != 0) begin
            n_fail++; $display("FAIL ld_outstanding: got %0d pending expected 0", ld_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
